// File: rtl/seg7_scan_driver.sv
// seg7_scan_driver
//   Multiplexed 7-segment scan driver. Walks DIGITS hex digits, one slot of
//   CLK_DIV clocks each, driving the shared segment lines and one digit enable.
//   Per-digit decimal point and blanking, optional leading-zero suppression and
//   PWM brightness. New display data is staged by `load` and committed only at
//   the end of a frame, so a frame never mixes old and new data.
// Ports
//   clk, rst         clock, synchronous active-high reset
//   din              hex data, digit i = din[4i+3:4i], digit 0 rightmost
//   dp_in, blank_in  per-digit decimal point / force-dark
//   lzs_en           leading-zero suppression enable
//   load             1-cycle strobe, captures din/dp_in/blank_in/lzs_en
//   brightness       lit sub-slots per slot (0 = dark), sampled live
//   pending          staged data waiting for the frame-end commit
//   frame_done       1-cycle pulse on the last cycle of the last digit slot
//   seg              {a,b,c,d,e,f,g,dp}, polarity per SEG_ACT_LOW
//   an               digit enables, polarity per AN_ACT_LOW
module seg7_scan_driver #(
  parameter int DIGITS      = 8,
  parameter int CLK_DIV     = 4096,
  parameter int BRIGHT_W    = 4,
  parameter int AN_ACT_LOW  = 1,
  parameter int SEG_ACT_LOW = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DIGITS*4-1:0]   din,
  input  logic [DIGITS-1:0]     dp_in,
  input  logic [DIGITS-1:0]     blank_in,
  input  logic                  lzs_en,
  input  logic                  load,
  input  logic [BRIGHT_W-1:0]   brightness,
  output logic                  pending,
  output logic                  frame_done,
  output logic [7:0]            seg,
  output logic [DIGITS-1:0]     an
);

  localparam int CNT_W     = $clog2(CLK_DIV);
  localparam int DIG_W     = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int SLICE_I   = CLK_DIV >> BRIGHT_W;
  localparam int CNT_MAX_I = CLK_DIV - 1;
  localparam int DIG_MAX_I = DIGITS - 1;

  localparam logic [CNT_W-1:0]  CNT_MAX = CNT_MAX_I[CNT_W-1:0];
  localparam logic [CNT_W-1:0]  SLICE   = SLICE_I[CNT_W-1:0];
  localparam logic [DIG_W-1:0]  DIG_MAX = DIG_MAX_I[DIG_W-1:0];
  // Inactive levels; XOR with these turns active-high internals into pin polarity.
  localparam logic [7:0]        SEG_OFF = (SEG_ACT_LOW != 0) ? 8'hFF : 8'h00;
  localparam logic [DIGITS-1:0] AN_OFF  = (AN_ACT_LOW != 0) ? {DIGITS{1'b1}} : {DIGITS{1'b0}};

  // Segment pattern, active-high abcdefg.
  function automatic logic [6:0] hex7(input logic [3:0] h);
    case (h)
      4'h0: hex7 = 7'h7E;  4'h1: hex7 = 7'h30;  4'h2: hex7 = 7'h6D;  4'h3: hex7 = 7'h79;
      4'h4: hex7 = 7'h33;  4'h5: hex7 = 7'h5B;  4'h6: hex7 = 7'h5F;  4'h7: hex7 = 7'h70;
      4'h8: hex7 = 7'h7F;  4'h9: hex7 = 7'h7B;  4'hA: hex7 = 7'h77;  4'hB: hex7 = 7'h1F;
      4'hC: hex7 = 7'h4E;  4'hD: hex7 = 7'h3D;  4'hE: hex7 = 7'h4F;  default: hex7 = 7'h47;
    endcase
  endfunction

  // Scan state
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [DIG_W-1:0] digit_q, digit_d;

  // Staging buffer (written by load)
  logic [DIGITS-1:0][3:0] stg_din_q, stg_din_d;
  logic [DIGITS-1:0]      stg_dp_q, stg_dp_d;
  logic [DIGITS-1:0]      stg_blank_q, stg_blank_d;
  logic                   stg_lzs_q, stg_lzs_d;
  logic                   pending_q, pending_d;

  // Active buffer (what is being displayed)
  logic [DIGITS-1:0][3:0] act_din_q, act_din_d;
  logic [DIGITS-1:0]      act_dp_q, act_dp_d;
  logic [DIGITS-1:0]      act_blank_q, act_blank_d;
  logic                   act_lzs_q, act_lzs_d;

  // Registered pin drivers
  logic [7:0]        seg_q, seg_d;
  logic [DIGITS-1:0] an_q, an_d;

  logic                   slot_end, frame_end, commit;
  logic [DIGITS-1:0]      supp;
  logic                   lz_run;
  logic [CNT_W-1:0]       sub, bright_ext;
  logic [3:0]             cur_hex;
  logic                   lit;
  logic [7:0]             seg_act;
  logic [DIGITS-1:0]      an_act;

  // Scan counters, staging and frame-end commit
  always_comb begin
    slot_end  = (cnt_q == CNT_MAX);
    frame_end = slot_end && (digit_q == DIG_MAX);
    commit    = frame_end && pending_q;

    cnt_d   = slot_end ? '0 : cnt_q + 1'b1;
    digit_d = digit_q;
    if (slot_end) digit_d = (digit_q == DIG_MAX) ? '0 : digit_q + 1'b1;

    act_din_d   = act_din_q;
    act_dp_d    = act_dp_q;
    act_blank_d = act_blank_q;
    act_lzs_d   = act_lzs_q;
    if (commit) begin
      act_din_d   = stg_din_q;
      act_dp_d    = stg_dp_q;
      act_blank_d = stg_blank_q;
      act_lzs_d   = stg_lzs_q;
    end

    // A load on the commit cycle lands in staging after the old contents
    // have moved to active, so pending stays set for the next frame.
    stg_din_d   = stg_din_q;
    stg_dp_d    = stg_dp_q;
    stg_blank_d = stg_blank_q;
    stg_lzs_d   = stg_lzs_q;
    pending_d   = pending_q && !commit;
    if (load) begin
      stg_din_d   = din;
      stg_dp_d    = dp_in;
      stg_blank_d = blank_in;
      stg_lzs_d   = lzs_en;
      pending_d   = 1'b1;
    end
  end

  // Leading-zero suppression: walk down from the top digit while digits are
  // zero without a dp; digit 0 always stays visible.
  always_comb begin
    supp   = '0;
    lz_run = act_lzs_q;
    for (int i = DIGITS - 1; i >= 1; i--) begin
      if (lz_run && (act_din_q[i] == 4'h0) && !act_dp_q[i]) supp[i] = 1'b1;
      else                                                   lz_run  = 1'b0;
    end
  end

  // Output decode. cnt==0 is forced dark so the enable never overlaps the
  // previous digit's segments at a slot change.
  always_comb begin
    sub        = cnt_q / SLICE;
    bright_ext = '0;
    bright_ext[BRIGHT_W-1:0] = brightness;
    cur_hex    = act_din_q[digit_q];
    lit        = !act_blank_q[digit_q] && !supp[digit_q] &&
                 (cnt_q != '0) && (sub < bright_ext);
    seg_act    = lit ? {hex7(cur_hex), act_dp_q[digit_q]} : 8'h00;
    an_act     = '0;
    if (lit) an_act[digit_q] = 1'b1;
    seg_d      = seg_act ^ SEG_OFF;
    an_d       = an_act ^ AN_OFF;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q       <= '0;
      digit_q     <= '0;
      stg_din_q   <= '0;
      stg_dp_q    <= '0;
      stg_blank_q <= '0;
      stg_lzs_q   <= 1'b0;
      pending_q   <= 1'b0;
      act_din_q   <= '0;
      act_dp_q    <= '0;
      act_blank_q <= '1;
      act_lzs_q   <= 1'b0;
      seg_q       <= SEG_OFF;
      an_q        <= AN_OFF;
    end else begin
      cnt_q       <= cnt_d;
      digit_q     <= digit_d;
      stg_din_q   <= stg_din_d;
      stg_dp_q    <= stg_dp_d;
      stg_blank_q <= stg_blank_d;
      stg_lzs_q   <= stg_lzs_d;
      pending_q   <= pending_d;
      act_din_q   <= act_din_d;
      act_dp_q    <= act_dp_d;
      act_blank_q <= act_blank_d;
      act_lzs_q   <= act_lzs_d;
      seg_q       <= seg_d;
      an_q        <= an_d;
    end
  end

  assign pending    = pending_q;
  assign frame_done = frame_end;
  assign seg        = seg_q;
  assign an         = an_q;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Bench for seg7_scan_driver (DIGITS=4, CLK_DIV=16, BRIGHT_W=2, active-low pins).
// A timeline model (cycles since reset -> slot/digit, plus staging/active
// buffers) predicts seg/an/pending/frame_done every cycle; directed loads
// exercise commit timing, LZS, blanking, PWM and reset, with literal pins.
module tb_seg7_scan_driver;
  localparam int DIGITS   = 4;
  localparam int CLK_DIV  = 16;
  localparam int BRIGHT_W = 2;
  localparam int FRAME    = CLK_DIV * DIGITS;
  localparam int SLICE    = CLK_DIV >> BRIGHT_W;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [15:0] din = '0;
  logic [3:0]  dp_in = '0, blank_in = '0;
  logic        lzs_en = 1'b0, load = 1'b0;
  logic [1:0]  brightness = '0;
  logic        pending, frame_done;
  logic [7:0]  seg;
  logic [3:0]  an;

  seg7_scan_driver #(.DIGITS(DIGITS), .CLK_DIV(CLK_DIV), .BRIGHT_W(BRIGHT_W),
                     .AN_ACT_LOW(1), .SEG_ACT_LOW(1)) dut (
    .clk(clk), .rst(rst), .din(din), .dp_in(dp_in), .blank_in(blank_in),
    .lzs_en(lzs_en), .load(load), .brightness(brightness),
    .pending(pending), .frame_done(frame_done), .seg(seg), .an(an));

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  // ---------------- model ----------------
  logic [6:0]  seg_tbl [16] = '{7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70,
                                7'h7F, 7'h7B, 7'h77, 7'h1F, 7'h4E, 7'h3D, 7'h4F, 7'h47};
  int          m_t;
  logic [15:0] m_stg_din, m_act_din;
  logic [3:0]  m_stg_dp, m_stg_blank, m_act_dp, m_act_blank;
  bit          m_stg_lzs, m_act_lzs, m_pending;
  bit          m_valid = 0, exp_ok = 0;
  logic [7:0]  exp_seg;
  logic [3:0]  exp_an;

  // Digit d is hidden when it and everything above it is zero with no dp.
  function automatic bit suppressed(input int d);
    return m_act_lzs && d != 0 && (m_act_din >> (4 * d)) == 0 && (m_act_dp >> d) == 0;
  endfunction

  initial begin
    forever begin
      @(negedge clk);
      if (exp_ok) begin
        chk("seg", seg, exp_seg);
        chk("an", an, exp_an);
      end
      if (m_valid) begin
        chk("pending", pending, m_pending);
        chk("frame_done", frame_done, (m_t % FRAME) == FRAME - 1);
      end
      // prediction for the registers loaded at the next edge
      exp_seg = 8'hFF;
      exp_an  = 4'hF;
      if (!rst && m_valid) begin
        int d, c;
        d = (m_t / CLK_DIV) % DIGITS;
        c = m_t % CLK_DIV;
        if (!m_act_blank[d] && !suppressed(d) && c != 0 && (c / SLICE) < brightness) begin
          exp_seg = ~{seg_tbl[m_act_din[4*d +: 4]], m_act_dp[d]};
          exp_an  = 4'hF;
          exp_an[d] = 1'b0;
        end
      end
      exp_ok = rst || m_valid;
      // advance model state over the next edge
      if (rst) begin
        m_t = 0; m_valid = 1; m_pending = 0;
        m_stg_din = '0; m_stg_dp = '0; m_stg_blank = '0; m_stg_lzs = 0;
        m_act_din = '0; m_act_dp = '0; m_act_blank = 4'hF; m_act_lzs = 0;
      end else if (m_valid) begin
        if ((m_t % FRAME) == FRAME - 1 && m_pending) begin
          m_act_din = m_stg_din; m_act_dp = m_stg_dp;
          m_act_blank = m_stg_blank; m_act_lzs = m_stg_lzs;
          m_pending = 0;
        end
        if (load) begin
          m_stg_din = din; m_stg_dp = dp_in; m_stg_blank = blank_in; m_stg_lzs = lzs_en;
          m_pending = 1;
        end
        m_t++;
      end
    end
  end

  // ---------------- stimulus ----------------
  int t_main;  // DUT scan state index; outputs seen now reflect t_main-1

  task automatic tick();
    @(posedge clk); #1; t_main++;
  endtask

  task automatic go(input int p);
    for (int i = 0; i < FRAME; i++) begin
      if ((t_main % FRAME) == p) break;
      tick();
    end
  endtask

  task automatic next_frame();
    go(FRAME - 1); tick();
  endtask

  task automatic do_load(input logic [15:0] d, input logic [3:0] dp,
                         input logic [3:0] bl, input bit lz);
    din = d; dp_in = dp; blank_in = bl; lzs_en = lz; load = 1'b1;
    tick();
    load = 1'b0;
  endtask

  task automatic pin(input string n, input logic [7:0] es, input logic [3:0] ea);
    chk({n, "_seg"}, seg, es);
    chk({n, "_an"}, an, ea);
  endtask

  initial begin
    int fd;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1; rst = 1'b0; t_main = 0;
    pin("reset", 8'hFF, 4'hF);
    chk("reset_pending", pending, 0);
    chk("reset_frame_done", frame_done, 0);

    // idle: dark, frame_done every 64 cycles
    fd = 0;
    repeat (200) begin tick(); if (frame_done === 1'b1) fd++; end
    chk("idle_fd_count", fd, 3);

    // 12AF at full brightness
    brightness = 2'd3;
    do_load(16'h12AF, 4'h0, 4'h0, 0);
    go(1);  pin("ghost", 8'hFF, 4'hF);
    go(2);  pin("d0_F", 8'h71, 4'hE);
    go(12); pin("d0_sub2", 8'h71, 4'hE);
    go(13); pin("d0_sub3", 8'hFF, 4'hF);
    go(18); pin("d1_A", 8'h11, 4'hD);

    // leading-zero suppression
    do_load(16'h0070, 4'h0, 4'h0, 1);
    next_frame();
    go(2);  pin("lzs_d0", 8'h03, 4'hE);
    go(18); pin("lzs_d1", 8'h1F, 4'hD);
    go(34); pin("lzs_d2", 8'hFF, 4'hF);
    go(50); pin("lzs_d3", 8'hFF, 4'hF);
    do_load(16'h0070, 4'b0100, 4'h0, 1);
    next_frame();
    go(34); pin("lzs_dp_d2", 8'h02, 4'hB);
    go(50); pin("lzs_dp_d3", 8'hFF, 4'hF);

    // last load wins, commit only at frame end
    go(10); do_load(16'h1111, 4'h0, 4'h0, 0);
    chk("A_pending", pending, 1);
    go(30); do_load(16'h2222, 4'h0, 4'b0010, 0);
    go(63); chk("B_pending_end", pending, 1);
    tick(); chk("B_committed", pending, 0);
    go(2);  pin("B_d0", 8'h25, 4'hE);
    go(18); pin("B_d1_blank", 8'hFF, 4'hF);

    // load coincident with frame_done
    go(20); do_load(16'h3333, 4'h0, 4'h0, 0);
    go(63); chk("coinc_fd", frame_done, 1);
    do_load(16'h4444, 4'h0, 4'h0, 0);
    chk("coinc_pending", pending, 1);
    go(2);  pin("C_d0", 8'h0D, 4'hE);
    next_frame();
    go(2);  pin("D_d0", 8'h99, 4'hE);
    chk("D_pending", pending, 0);

    // live brightness
    brightness = 2'd1;
    go(18); pin("br1_sub0", 8'h99, 4'hD);
    go(22); pin("br1_sub1", 8'hFF, 4'hF);
    brightness = 2'd0;
    go(34); pin("br0", 8'hFF, 4'hF);
    brightness = 2'd3;

    // reset in the middle of digit 2 with data staged
    go(34); do_load(16'h5555, 4'h0, 4'h0, 0);
    go(40);
    rst = 1'b1; tick(); rst = 1'b0; t_main = 0;
    pin("rst_mid", 8'hFF, 4'hF);
    chk("rst_pending", pending, 0);
    go(62); chk("rst_fd_62", frame_done, 0);
    tick(); chk("rst_fd_63", frame_done, 1);
    repeat (70) tick();
    pin("rst_dark", 8'hFF, 4'hF);
    chk("rst_no_commit", pending, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
